mem_arbiter: RTL and testbench

Shares the single-port, byte-wide program/data memory between the instruction-fetch path and the load/store path of the nano CPU. Each requester issues 32-bit word requests; the arbiter grants one at a time round-robin, sequences four byte beats to the memory, assembles or splits the word with per-port byte order, and returns a one-cycle response pulse. It sits between `proc` and the memory array, replacing direct multi-byte array indexing.

---
 rtl/mem_arbiter_pkg.sv | 35 +++
 rtl/mem_arbiter_rr_arb2.sv | 53 +++++
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide memory arbiter: FSM states, port ids,
// beat count and byte-lane helpers used by the fetch and load/store paths.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int         BEAT_CNT  = 4;
    localparam logic [1:0] LAST_BEAT = 2'(BEAT_CNT - 1);

    // Fetch words are little-endian (beat k -> byte lane k); load/store words
    // are big-endian (beat k -> byte lane 3-k).
    function automatic logic [1:0] byte_lane(input logic port, input logic [1:0] beat);
        logic [1:0] lane;
        if (port == PORT_IF) begin
            lane = beat;
        end else begin
            lane = 2'd3 - beat;
        end
        return lane;
    endfunction

    // Extract one byte lane from a 32-bit word.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin grant. The grant is combinational from the
// request lines; the last-granted port is remembered so a tie goes to the
// other port. After reset the data port counts as last granted, so fetch
// wins the first tie.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,    // indexed by port id
    input  logic       i_en,     // grants allowed this cycle
    output logic       o_valid,
    output logic       o_id
);

    logic r_last_grant;

    // Pick the requester: a lone request wins, a tie goes away from last grant.
    always_comb begin
        o_valid = 1'b0;
        o_id    = PORT_IF;
        if (i_en) begin
            if (i_req[PORT_IF] && i_req[PORT_D]) begin
                o_valid = 1'b1;
                o_id    = ~r_last_grant;
            end else if (i_req[PORT_IF]) begin
                o_valid = 1'b1;
                o_id    = PORT_IF;
            end else if (i_req[PORT_D]) begin
                o_valid = 1'b1;
                o_id    = PORT_D;
            end else begin
                o_valid = 1'b0;
                o_id    = PORT_IF;
            end
        end else begin
            o_valid = 1'b0;
            o_id    = PORT_IF;
        end
    end

    // Remember which port was granted most recently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= PORT_D;
        end else if (o_valid) begin
            r_last_grant <= o_id;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port byte-wide memory between instruction fetch and
// load/store. Each granted 32-bit request becomes four byte beats; reads are
// assembled per port byte order and returned with a one-cycle response pulse
// six cycles after the handshake.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [31:0]       if_addr,
    output logic              if_resp_valid,
    output logic [31:0]       if_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_resp_valid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_t            r_state;
    logic [1:0]        r_beat;
    logic              r_port;
    logic              r_we;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;
    logic [1:0]        r_mem_beat;   // beat currently on the memory bus
    logic              r_cap_en;     // mem_rdata holds a read byte this cycle
    logic [1:0]        r_cap_beat;   // beat that byte belongs to
    logic [31:0]       r_asm;        // read word under assembly

    logic              w_gnt_valid;
    logic              w_gnt_id;
    logic              w_arb_en;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_req_we;
    logic [1:0]        w_next_beat;
    logic [ADDR_W-1:0] w_next_addr;
    logic [1:0]        w_cap_lane;
    logic [31:0]       w_asm_next;
    logic              w_unused_addr_bits;

    // Address bits above the memory width are ignored by design.
    assign w_unused_addr_bits = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

    // Grants are only offered while idle and out of reset.
    assign w_arb_en = (r_state == ST_IDLE) && !rst;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .i_req   ({d_req_valid, if_req_valid}),
        .i_en    (w_arb_en),
        .o_valid (w_gnt_valid),
        .o_id    (w_gnt_id)
    );

    assign if_req_ready = w_gnt_valid && (w_gnt_id == PORT_IF);
    assign d_req_ready  = w_gnt_valid && (w_gnt_id == PORT_D);

    assign w_req_addr  = (w_gnt_id == PORT_D) ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
    assign w_req_we    = (w_gnt_id == PORT_D) && d_we;
    assign w_next_beat = r_beat + 2'd1;
    assign w_next_addr = r_base + {{(ADDR_W-2){1'b0}}, w_next_beat};
    assign w_cap_lane  = byte_lane(r_port, r_cap_beat);

    // Merge the byte returned this cycle into the word under assembly.
    always_comb begin
        w_asm_next = r_asm;
        if (r_cap_en) begin
            w_asm_next[{w_cap_lane, 3'b000} +: 8] = mem_rdata;
        end else begin
            w_asm_next = r_asm;
        end
    end

    // Track which read byte arrives next cycle and accumulate the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_en   <= 1'b0;
            r_cap_beat <= 2'd0;
            r_asm      <= 32'd0;
        end else begin
            r_cap_en   <= mem_en && !mem_we;
            r_cap_beat <= r_mem_beat;
            r_asm      <= w_asm_next;
        end
    end

    // Access sequencer: grant, four byte beats, wait for last byte, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_beat        <= 2'd0;
            r_port        <= PORT_IF;
            r_we          <= 1'b0;
            r_base        <= '0;
            r_wdata       <= 32'd0;
            r_mem_beat    <= 2'd0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= 8'd0;
            if_resp_valid <= 1'b0;
            d_resp_valid  <= 1'b0;
            if_rdata      <= 32'd0;
            d_rdata       <= 32'd0;
        end else begin
            if_resp_valid <= 1'b0;
            d_resp_valid  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_state    <= ST_ISSUE;
                        r_beat     <= 2'd0;
                        r_port     <= w_gnt_id;
                        r_we       <= w_req_we;
                        r_base     <= w_req_addr;
                        r_wdata    <= d_wdata;
                        r_mem_beat <= 2'd0;
                        mem_en     <= 1'b1;
                        mem_we     <= w_req_we;
                        mem_addr   <= w_req_addr;
                        mem_wdata  <= w_req_we ? word_byte(d_wdata, byte_lane(PORT_D, 2'd0)) : 8'd0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (r_beat == LAST_BEAT) begin
                        r_state   <= ST_WAIT;
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= 8'd0;
                    end else begin
                        r_beat     <= w_next_beat;
                        r_mem_beat <= w_next_beat;
                        mem_addr   <= w_next_addr;
                        mem_wdata  <= r_we ? word_byte(r_wdata, byte_lane(r_port, w_next_beat)) : 8'd0;
                    end
                end
                ST_WAIT: begin
                    r_state <= ST_RESP;
                    if (r_port == PORT_IF) begin
                        if_rdata      <= w_asm_next;
                        if_resp_valid <= 1'b1;
                    end else begin
                        d_rdata      <= r_we ? 32'd0 : w_asm_next;
                        d_resp_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte memory model, word-level
// reference memory, directed scenarios plus randomized word traffic.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [31:0] if_addr = 32'd0;
    logic        if_resp_valid;
    logic [31:0] if_rdata;
    logic        d_req_valid = 1'b0;
    logic        d_req_ready;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_resp_valid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = 16'd0;
    logic [7:0]  pl_data = 8'd0;

    logic [7:0]  mem_arr [65536];
    logic [7:0]  ref_mem [65536];
    logic [15:0] seen_addr [4];

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.ADDR_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_resp_valid (if_resp_valid),
        .if_rdata      (if_rdata),
        .d_req_valid   (d_req_valid),
        .d_req_ready   (d_req_ready),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_resp_valid  (d_resp_valid),
        .d_rdata       (d_rdata),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte memory with synchronous read; preload port used during reset.
    always @(posedge clk) begin
        if (pl_en) begin
            mem_arr[pl_addr] <= pl_data;
        end else if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        ref_mem[a] = v;
    endtask

    // Reference word read: fetch little-endian, load big-endian, wrapping at 64K.
    function automatic logic [31:0] ref_word(input bit port, input logic [31:0] addr);
        logic [15:0] a0, a1, a2, a3;
        a0 = addr[15:0]; a1 = a0 + 16'd1; a2 = a0 + 16'd2; a3 = a0 + 16'd3;
        if (port == 1'b0) return {ref_mem[a3], ref_mem[a2], ref_mem[a1], ref_mem[a0]};
        else              return {ref_mem[a0], ref_mem[a1], ref_mem[a2], ref_mem[a3]};
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [31:0] wd);
        logic [15:0] a;
        logic [31:0] w;
        a = addr[15:0];
        w = wd;
        for (int i = 0; i < 4; i++) begin
            ref_mem[a] = w[31:24];
            w = w << 8;
            a = a + 16'd1;
        end
    endtask

    task automatic handshake(input bit port, input bit we, input logic [31:0] addr,
                             input logic [31:0] wd, input string tag);
        bit got;
        got = 1'b0;
        @(negedge clk);
        if (port == 1'b0) begin
            if_req_valid = 1'b1; if_addr = addr;
        end else begin
            d_req_valid = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end
        for (int t = 0; t < 20 && !got; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            if ((port ? d_req_ready : if_req_ready) === 1'b1) got = 1'b1;
        end
        chk({tag, " handshake"}, 32'(got), 32'd1);
    endtask

    // Assumes the handshake happened in the cycle just sampled (cycle 0).
    task automatic wait_resp(input bit port, input logic [31:0] exp, input string tag);
        int n_resp, resp_cyc, n_other;
        n_resp = 0; resp_cyc = -1; n_other = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin if_req_valid = 1'b0; d_req_valid = 1'b0; end
            #1;
            if (k <= 4) seen_addr[k-1] = mem_addr;
            if ((port ? d_resp_valid : if_resp_valid) === 1'b1) begin
                n_resp++; resp_cyc = k;
            end
            if ((port ? if_resp_valid : d_resp_valid) === 1'b1) n_other++;
        end
        chk({tag, " resp count"}, 32'(n_resp), 32'd1);
        chk({tag, " resp cycle"}, 32'(resp_cyc), 32'd6);
        chk({tag, " other resp"}, 32'(n_other), 32'd0);
        chk({tag, " rdata"}, port ? d_rdata : if_rdata, exp);
    endtask

    task automatic do_op(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input string tag);
        logic [31:0] exp;
        exp = (port && we) ? 32'd0 : ref_word(port, addr);
        handshake(port, we, addr, wd, tag);
        wait_resp(port, exp, tag);
        if (port && we) ref_store(addr, wd);
    endtask

    task automatic chk_seen(input string tag, input logic [15:0] base);
        logic [15:0] a;
        a = base;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s mem_addr beat%0d", tag, i), 32'(seen_addr[i]), 32'(a));
            a = a + 16'd1;
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " mem_en"},        32'(mem_en), 32'd0);
        chk({tag, " mem_we"},        32'(mem_we), 32'd0);
        chk({tag, " mem_addr"},      32'(mem_addr), 32'd0);
        chk({tag, " mem_wdata"},     32'(mem_wdata), 32'd0);
        chk({tag, " if_resp_valid"}, 32'(if_resp_valid), 32'd0);
        chk({tag, " d_resp_valid"},  32'(d_resp_valid), 32'd0);
        chk({tag, " if_rdata"},      if_rdata, 32'd0);
        chk({tag, " d_rdata"},       d_rdata, 32'd0);
    endtask

    initial begin
        int          g_cyc[$];
        bit          g_port[$];
        int          n_both;
        int          n_dresp;
        bit          port, we;
        logic [15:0] lo;
        logic [31:0] r, addr, wd;

        // Preload 0x0000-0x007F and 0xFFF0-0xFFFF while in reset.
        for (int i = 0; i < 128; i++) begin
            if (i == 0)      preload(16'(i), 8'h13);
            else if (i == 1) preload(16'(i), 8'h00);
            else if (i == 2) preload(16'(i), 8'h50);
            else if (i == 3) preload(16'(i), 8'h00);
            else             preload(16'(i), 8'($urandom));
        end
        for (int i = 0; i < 16; i++) preload(16'hFFF0 + 16'(i), 8'($urandom));
        @(negedge clk);
        pl_en = 1'b0;

        // Reset state, with both requests already asserted.
        if_req_valid = 1'b1; if_addr = 32'h0000_0000;
        d_req_valid  = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0050;
        #1;
        chk_zero_outputs("reset");
        chk("reset if_req_ready", 32'(if_req_ready), 32'd0);
        chk("reset d_req_ready",  32'(d_req_ready),  32'd0);

        // Contention from reset: IF, D, IF, D... every 7 cycles.
        n_both = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (if_req_ready === 1'b1 && d_req_ready === 1'b1) n_both++;
            if (if_req_ready === 1'b1) begin g_cyc.push_back(c); g_port.push_back(1'b0); end
            if (d_req_ready === 1'b1)  begin g_cyc.push_back(c); g_port.push_back(1'b1); end
        end
        chk("contention both ready", 32'(n_both), 32'd0);
        chk("contention grant count", 32'(g_cyc.size()), 32'd5);
        for (int i = 0; i < g_cyc.size() && i < 5; i++) begin
            chk($sformatf("contention grant%0d cycle", i), 32'(g_cyc[i]), 32'(7 * i));
            chk($sformatf("contention grant%0d port", i), 32'(g_port[i]), 32'(i % 2));
        end
        @(negedge clk);
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (8) @(negedge clk);

        // Directed fetch of the first instruction word.
        do_op(1'b0, 1'b0, 32'h0000_0000, 32'd0, "fetch0");
        chk("fetch0 word", if_rdata, 32'h0050_0013);
        chk_seen("fetch0", 16'h0000);

        // Store then load at 0x50.
        do_op(1'b1, 1'b1, 32'h0000_0050, 32'hDEAD_BEEF, "store50");
        chk("store50 bytes", {mem_arr[16'h50], mem_arr[16'h51], mem_arr[16'h52], mem_arr[16'h53]},
            32'hDEAD_BEEF);
        do_op(1'b1, 1'b0, 32'h0000_0050, 32'd0, "load50");
        chk("load50 word", d_rdata, 32'hDEAD_BEEF);

        // Wrapping load at the top of memory, upper address bits set.
        do_op(1'b1, 1'b0, 32'hABCD_FFFE, 32'd0, "wrapload");
        chk_seen("wrapload", 16'hFFFE);

        // Randomized traffic over the preloaded regions.
        for (int n = 0; n < 40; n++) begin
            port = 1'($urandom_range(0, 1));
            we   = port ? 1'($urandom_range(0, 1)) : 1'b0;
            if ($urandom_range(0, 3) == 0) lo = 16'hFFF0 + 16'($urandom_range(0, 15));
            else                           lo = 16'($urandom_range(0, 16'h7C));
            r    = $urandom;
            addr = {r[31:16], lo};
            wd   = $urandom;
            do_op(port, we, addr, wd, $sformatf("rand%0d", n));
        end

        // Reset in cycle 3 of a store to 0x10: beats 0 and 1 already written.
        handshake(1'b1, 1'b1, 32'h0000_0010, 32'hA1B2_C3D4, "rststore");
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) d_req_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk_zero_outputs("midreset");
        ref_mem[16'h10] = 8'hA1;
        ref_mem[16'h11] = 8'hB2;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_dresp = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (d_resp_valid === 1'b1) n_dresp++;
        end
        chk("rststore no response", 32'(n_dresp), 32'd0);
        chk("rststore partial bytes", {mem_arr[16'h10], mem_arr[16'h11]}, 32'h0000_A1B2);

        // Tie after reset: fetch wins, data request withdrawn without response.
        @(negedge clk);
        if_req_valid = 1'b1; if_addr = 32'h0000_0010;
        d_req_valid  = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0020;
        #1;
        chk("post-rst tie if_ready", 32'(if_req_ready), 32'd1);
        chk("post-rst tie d_ready",  32'(d_req_ready),  32'd0);
        wait_resp(1'b0, ref_word(1'b0, 32'h0000_0010), "post-rst fetch");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
